// File: rtl/jtpopeye_objdma.sv
// jtpopeye_objdma -- object-table DMA engine with a double-buffered table.
//
// On a rising edge of VB (when armed by enable) the engine requests the CPU
// bus, copies ENTRIES*BPE bytes starting at BASE into the back bank of an
// internal object table, then swaps banks so the object engine sees a
// complete, consistent table on the front bank.
//
// Ports
//   clk, rst_n      clock, synchronous active-low reset
//   cen             clock enable; all DMA state advances only on cen=1
//   VB              vertical blank; rise starts a transfer, fall aborts it
//   enable          gates the IDLE->REQ decision only
//   busak_n         CPU bus acknowledge (active low)
//   DD_DMA          source data, valid one cen after AD_DMA/dma_cs
//   busrq_n         CPU bus request (active low)
//   dma_cs, AD_DMA  source read strobe and address
//   rd_addr/rd_data front-bank entry read port, 1 clk latency, ignores cen
//   bank            index of the current front bank
//   busy            engine not idle
//   done, abort     one-clk pulses: successful swap / aborted transfer
//
// Bus handshake: busrq_n is held low from REQ until release; a byte is
// issued only on a cen where busak_n=0 is sampled in XFER. If busak_n goes
// high in XFER the engine pauses (counter held, dma_cs low) but keeps
// requesting. Data is captured on the cen after it was addressed, so a pause
// never loses the byte already in flight.
module jtpopeye_objdma #(
  parameter int            AW      = 10,
  parameter int            DW      = 8,
  parameter int            ENTRIES = 64,
  parameter int            BPE     = 4,
  parameter logic [AW-1:0] BASE    = '0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       cen,
  input  logic                       VB,
  input  logic                       enable,
  input  logic                       busak_n,
  input  logic [DW-1:0]              DD_DMA,
  output logic                       busrq_n,
  output logic                       dma_cs,
  output logic [AW-1:0]              AD_DMA,
  input  logic [$clog2(ENTRIES)-1:0] rd_addr,
  output logic [DW*BPE-1:0]          rd_data,
  output logic                       bank,
  output logic                       busy,
  output logic                       done,
  output logic                       abort
);

  localparam int EW = $clog2(ENTRIES);
  localparam int NB = ENTRIES * BPE;
  localparam int CW = $clog2(NB + 1);
  localparam int BW = (BPE > 1) ? $clog2(BPE) : 1;
  localparam logic [CW-1:0] LAST = CW'(NB - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT_ACK,
    S_XFER,
    S_DRAIN,
    S_REL
  } state_t;

  state_t        state, state_d;
  logic          vb_last;
  logic          rise;
  logic [CW-1:0] cnt;
  logic [CW-1:0] wr_off;   // table offset of the byte currently on DD_DMA

  logic start, issue, go_abort, go_done, clr_cnt;

  assign rise = VB & ~vb_last;
  assign busy = (state != S_IDLE);

  // Next-state and per-cen control decisions
  always_comb begin
    state_d  = state;
    start    = 1'b0;
    issue    = 1'b0;
    go_abort = 1'b0;
    go_done  = 1'b0;
    clr_cnt  = 1'b0;
    case (state)
      S_IDLE: begin
        if (rise && enable) begin
          state_d = S_REQ;
          start   = 1'b1;
        end
      end
      S_REQ: state_d = S_WAIT_ACK;
      S_WAIT_ACK: begin
        if (!busak_n) begin
          state_d = S_XFER;
          clr_cnt = 1'b1;
        end
      end
      S_XFER: begin
        if (!busak_n) begin
          issue = 1'b1;
          if (cnt == LAST) state_d = S_DRAIN;
        end
      end
      S_DRAIN: state_d = S_REL;
      S_REL: begin
        state_d = S_IDLE;
        go_done = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
    // Losing VB before the swap abandons the frame; REL is already committed.
    if (!VB && (state == S_REQ || state == S_WAIT_ACK ||
                state == S_XFER || state == S_DRAIN)) begin
      state_d  = S_IDLE;
      issue    = 1'b0;
      clr_cnt  = 1'b0;
      go_abort = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      vb_last <= 1'b0;
      busrq_n <= 1'b1;
      dma_cs  <= 1'b0;
      AD_DMA  <= '0;
      bank    <= 1'b0;
      done    <= 1'b0;
      abort   <= 1'b0;
      cnt     <= '0;
      wr_off  <= '0;
    end else begin
      done  <= 1'b0;
      abort <= 1'b0;
      if (cen) begin
        state   <= state_d;
        vb_last <= VB;
        dma_cs  <= issue;
        if (start) busrq_n <= 1'b0;
        if (go_abort || go_done) busrq_n <= 1'b1;
        if (clr_cnt) cnt <= '0;
        if (issue) begin
          AD_DMA <= BASE + AW'(cnt);
          wr_off <= cnt;
          cnt    <= cnt + CW'(1);
        end
        if (go_done) begin
          bank <= ~bank;
          done <= 1'b1;
        end
        abort <= go_abort;
      end
    end
  end

  // Capture path: the byte addressed on the previous cen lands now, always
  // in the back bank, so reads of the front bank never collide with it.
  logic          wr_en;
  logic [EW-1:0] wr_entry;
  logic [BW-1:0] wr_byte;

  assign wr_en    = cen & dma_cs & rst_n;
  assign wr_entry = EW'(wr_off / CW'(BPE));
  assign wr_byte  = BW'(wr_off % CW'(BPE));

  // One RAM per byte lane so a whole entry is read in a single clock.
  for (genvar j = 0; j < BPE; j++) begin : g_lane
    logic [DW-1:0] ram [2*ENTRIES];
    logic [DW-1:0] q;

    always_ff @(posedge clk) begin
      if (wr_en && wr_byte == BW'(j)) ram[{~bank, wr_entry}] <= DD_DMA;
    end

    always_ff @(posedge clk) begin
      if (!rst_n) q <= '0;
      else        q <= ram[{bank, rd_addr}];
    end

    assign rd_data[DW*j +: DW] = q;
  end

endmodule

// File: tb/tb_jtpopeye_objdma.sv
// Testbench for jtpopeye_objdma: ENTRIES=4, BPE=4, BASE=0x100.
// Source memory is a byte array answering AD_DMA; a table model (two banks
// of whole entries plus a front index) is updated once per completed frame.
module tb_jtpopeye_objdma;

  localparam int            AW      = 10;
  localparam int            DW      = 8;
  localparam int            ENTRIES = 4;
  localparam int            BPE     = 4;
  localparam int            EW      = $clog2(ENTRIES);
  localparam int            NB      = ENTRIES * BPE;
  localparam logic [AW-1:0] BASE    = 10'h100;

  // ---------------- clock / reset / DUT ----------------
  logic              clk = 1'b0;
  logic              rst_n, cen, VB, enable, busak_n;
  logic [DW-1:0]     DD_DMA;
  logic              busrq_n, dma_cs, bank, busy, done, abort;
  logic [AW-1:0]     AD_DMA;
  logic [EW-1:0]     rd_addr;
  logic [DW*BPE-1:0] rd_data;

  always #5 clk = ~clk;

  jtpopeye_objdma #(
    .AW(AW), .DW(DW), .ENTRIES(ENTRIES), .BPE(BPE), .BASE(BASE)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cen(cen), .VB(VB), .enable(enable),
    .busak_n(busak_n), .DD_DMA(DD_DMA), .busrq_n(busrq_n), .dma_cs(dma_cs),
    .AD_DMA(AD_DMA), .rd_addr(rd_addr), .rd_data(rd_data), .bank(bank),
    .busy(busy), .done(done), .abort(abort)
  );

  logic [7:0] src_mem [1024];
  assign DD_DMA = src_mem[AD_DMA];

  // ---------------- scoreboard / model ----------------
  int             n_vec;
  int             n_miss;
  logic [31:0]    tbl [2][ENTRIES];
  bit             tbl_ok [2];
  int             exp_bank;
  logic [AW-1:0]  exp_q [$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_vec++;
    if (got !== want) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, want, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic clk_step(input logic c);
    cen = c;
    @(posedge clk);
    #1;
  endtask

  // A random number of idle clocks followed by one enabled clock.
  task automatic do_cen();
    int g;
    g = $urandom_range(0, 2);
    for (int i = 0; i < g; i++) clk_step(1'b0);
    clk_step(1'b1);
  endtask

  task automatic fill_src(input bit ramp);
    for (int a = 0; a < 1024; a++) src_mem[a] = ramp ? a[7:0] : 8'($urandom);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, " busrq_n"}, busrq_n, 1);
    check({tag, " dma_cs"},  dma_cs,  0);
    check({tag, " AD_DMA"},  AD_DMA,  0);
    check({tag, " bank"},    bank,    0);
    check({tag, " busy"},    busy,    0);
    check({tag, " done"},    done,    0);
    check({tag, " abort"},   abort,   0);
    check({tag, " rd_data"}, rd_data, 0);
  endtask

  task automatic read_all(input string tag);
    if (!tbl_ok[exp_bank]) return;
    for (int e = 0; e < ENTRIES; e++) begin
      rd_addr = EW'(e);
      clk_step(1'($urandom_range(0, 1)));
      check({tag, " rd_data"}, rd_data, tbl[exp_bank][e]);
    end
  endtask

  // kill_kind: 0 none, 1 VB fall after kill_at bytes, 2 reset after kill_at bytes
  task automatic run_frame(input string tag, input int pause_at, input int pause_len,
                           input int kill_at, input int kill_kind);
    logic [31:0] ent [ENTRIES];
    int issued, bus_cens, pause_left, n_cs;
    bit finished;
    for (int e = 0; e < ENTRIES; e++)
      for (int j = 0; j < BPE; j++)
        ent[e][8*j +: 8] = src_mem[int'(BASE) + e*BPE + j];
    exp_q.delete();
    for (int i = 0; i < NB; i++) exp_q.push_back(BASE + AW'(i));

    VB = 1'b0; busak_n = 1'b1; enable = 1'b1;
    do_cen();
    VB = 1'b1;
    do_cen();
    check({tag, " req busrq_n"}, busrq_n, 0);
    check({tag, " req busy"}, busy, 1);
    enable = 1'($urandom_range(0, 1));
    do_cen();
    repeat ($urandom_range(0, 2)) do_cen();
    check({tag, " wait busrq_n"}, busrq_n, 0);
    check({tag, " wait dma_cs"}, dma_cs, 0);
    busak_n = 1'b0;
    do_cen();

    issued = 0; bus_cens = 0; pause_left = pause_len; n_cs = 0; finished = 0;
    for (int k = 0; k < 100 && !finished; k++) begin
      if (kill_kind == 1 && issued == kill_at) begin
        VB = 1'b0;
        do_cen();
        check({tag, " abort pulse"}, abort, 1);
        check({tag, " abort busrq_n"}, busrq_n, 1);
        check({tag, " abort dma_cs"}, dma_cs, 0);
        check({tag, " abort busy"}, busy, 0);
        check({tag, " abort bank"}, bank, exp_bank);
        clk_step(1'b0);
        check({tag, " abort width"}, abort, 0);
        tbl_ok[exp_bank ^ 1] = 0;
        busak_n = 1'b1;
        read_all(tag);
        return;
      end
      if (kill_kind == 2 && issued == kill_at) begin
        rst_n = 1'b0; VB = 1'b0; busak_n = 1'b1;
        clk_step(1'($urandom_range(0, 1)));
        rst_n = 1'b1;
        check_reset_vals({tag, " rst"});
        tbl_ok[exp_bank ^ 1] = 0;
        exp_bank = 0;
        read_all(tag);
        return;
      end
      busak_n = (issued == pause_at && pause_left > 0) ? 1'b1 : 1'b0;
      if (busak_n) pause_left--;
      do_cen();
      bus_cens++;
      if (busak_n) begin
        check({tag, " pause dma_cs"}, dma_cs, 0);
        check({tag, " pause AD_DMA"}, AD_DMA, int'(BASE) + issued - 1);
      end
      if (dma_cs) begin
        n_cs++;
        check({tag, " addr_left"}, exp_q.size() > 0, 1);
        if (exp_q.size() > 0) check({tag, " AD_DMA"}, AD_DMA, exp_q.pop_front());
        issued++;
      end
      if (busrq_n) finished = 1;
    end
    busak_n = 1'b1;
    check({tag, " finished"}, finished, 1);
    check({tag, " done"}, done, 1);
    check({tag, " bus time"}, bus_cens, NB + 2 + pause_len);
    check({tag, " cs count"}, n_cs, NB);
    check({tag, " q empty"}, exp_q.size(), 0);
    check({tag, " busy end"}, busy, 0);
    clk_step(1'b0);
    check({tag, " done width"}, done, 0);
    for (int e = 0; e < ENTRIES; e++) tbl[exp_bank ^ 1][e] = ent[e];
    tbl_ok[exp_bank ^ 1] = 1;
    exp_bank ^= 1;
    check({tag, " bank"}, bank, exp_bank);
    read_all(tag);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    n_vec = 0; n_miss = 0; exp_bank = 0;
    tbl_ok[0] = 0; tbl_ok[1] = 0;
    rst_n = 1'b0; cen = 1'b0; VB = 1'b0; enable = 1'b0; busak_n = 1'b1; rd_addr = '0;
    fill_src(1'b1);
    repeat (3) clk_step(1'($urandom_range(0, 1)));
    check_reset_vals("reset");
    rst_n = 1'b1;

    // enable low at the VB rise: nothing starts, and holding VB high is not a new rise
    do_cen();
    VB = 1'b1;
    for (int i = 0; i < 4; i++) begin
      busak_n = 1'($urandom_range(0, 1));
      do_cen();
      check("noen busrq_n", busrq_n, 1);
      check("noen dma_cs", dma_cs, 0);
      check("noen busy", busy, 0);
      enable = (i >= 2);
    end

    // plain frame with ramp data
    run_frame("f1", 99, 0, 0, 0);
    rd_addr = EW'(2);
    clk_step(1'b0);
    check("f1 entry2", rd_data, 32'h0B0A0908);

    // same data, 3-cen bus loss after the 5th byte
    run_frame("f2", 5, 3, 0, 0);

    // VB falls after 6 bytes
    fill_src(1'b0);
    run_frame("f3", 99, 0, 6, 1);

    // reset during transfer after 7 bytes, then a clean restart
    fill_src(1'b0);
    run_frame("f4", 99, 0, 7, 2);

    // back-to-back frames, then random frames with random pauses
    for (int f = 0; f < 6; f++) begin
      fill_src(1'b0);
      run_frame($sformatf("r%0d", f), $urandom_range(1, NB - 1), $urandom_range(0, 3), 0, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
